// File: rtl/irq_sequencer.sv
// irq_sequencer: machine-mode interrupt sequencer for the 3-stage core.
//
// Synchronises the external interrupt pin, arbitrates it against the timer
// interrupt (MEI over MTI), waits for a clean execute-stage instruction
// boundary, then drives the flush/redirect/CSR-update pulses that take the
// trap. While in the handler it watches for mret and sequences the return.
//
// Ports:
//   clk, reset                  core clock, synchronous active-high reset
//   intrpt                      asynchronous external interrupt pin
//   timer_irq                   level timer interrupt (MTIP), synchronous
//   csr_mie_bit, csr_meie/mtie  mstatus.MIE, mie.MEIE, mie.MTIE
//   csr_mtvec, csr_mepc         trap vector and current mepc
//   ex_valid/pc/stall/br_taken/mret  execute-stage status
//   irq_flush, irq_redirect, irq_pc  pipeline squash and PC redirect
//   mepc_we/wdata, mcause_we/wdata   CSR writes on trap entry
//   mie_save, mie_restore       mstatus MIE/MPIE stacking
//   mip_meip                    pending external interrupt (mip.MEIP)
//   in_handler                  high from trap entry until mret retires
module irq_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        intrpt,
    input  logic        timer_irq,
    input  logic        csr_mie_bit,
    input  logic        csr_meie,
    input  logic        csr_mtie,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_stall,
    input  logic        ex_br_taken,
    input  logic        ex_mret,
    output logic        irq_flush,
    output logic        irq_redirect,
    output logic [31:0] irq_pc,
    output logic        mepc_we,
    output logic [31:0] mepc_wdata,
    output logic        mcause_we,
    output logic [31:0] mcause_wdata,
    output logic        mie_save,
    output logic        mie_restore,
    output logic        mip_meip,
    output logic        in_handler
);

    typedef enum logic [1:0] {StIdle, StArm, StTake, StHandler} state_e;

    state_e      state_q;
    logic        sync1_q, sync2_q, sync3_q;
    logic        meip_pend_q;
    logic        cause_ext_q;   // latched cause: 1 = MEI, 0 = MTI
    logic [31:0] mepc_q;
    logic [31:0] irq_pc_q;

    logic        rise;
    logic        ext_en, tmr_en, any_irq;
    logic        boundary, src_live;
    logic        take, mret_fire;
    logic [3:0]  cause;
    logic [31:0] trap_vec;

    // sync3_q only remembers the previous synchronised level for edge detect
    assign rise      = sync2_q & ~sync3_q;
    assign ext_en    = meip_pend_q & csr_meie;
    assign tmr_en    = timer_irq & csr_mtie;
    assign any_irq   = (ext_en | tmr_en) & csr_mie_bit;
    assign boundary  = ex_valid & ~ex_stall & ~ex_br_taken & ~ex_mret;
    assign src_live  = cause_ext_q ? ext_en : tmr_en;
    assign take      = (state_q == StTake);
    assign mret_fire = (state_q == StHandler) & ex_mret & ex_valid & ~ex_stall;
    assign cause     = cause_ext_q ? 4'd11 : 4'd7;

    always_comb begin
        trap_vec = {csr_mtvec[31:2], 2'b00};
        if (csr_mtvec[1:0] == 2'b01) begin
            trap_vec = trap_vec + {26'b0, cause, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            meip_pend_q <= 1'b0;
            cause_ext_q <= 1'b0;
            mepc_q      <= 32'h0;
            irq_pc_q    <= RESET_VEC;
        end else begin
            sync1_q <= intrpt;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;

            // A new edge wins over the clear in TAKE
            if (rise) begin
                meip_pend_q <= 1'b1;
            end else if (take && cause_ext_q) begin
                meip_pend_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (any_irq) begin
                        cause_ext_q <= ext_en;
                        state_q     <= StArm;
                    end
                end
                StArm: begin
                    if (!csr_mie_bit || !src_live) begin
                        state_q <= StIdle;
                    end else if (boundary) begin
                        // Boundary instruction is squashed and re-executes
                        mepc_q   <= ex_pc;
                        irq_pc_q <= trap_vec;
                        state_q  <= StTake;
                    end
                end
                StTake: begin
                    state_q <= StHandler;
                end
                StHandler: begin
                    if (mret_fire) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // TAKE pulses decode the state register; mret pulses are combinational
    assign irq_flush    = take | mret_fire;
    assign irq_redirect = take | mret_fire;
    assign irq_pc       = take ? irq_pc_q : (mret_fire ? csr_mepc : 32'h0);
    assign mepc_we      = take;
    assign mepc_wdata   = take ? mepc_q : 32'h0;
    assign mcause_we    = take;
    assign mcause_wdata = take ? {1'b1, 27'b0, cause} : 32'h0;
    assign mie_save     = take;
    assign mie_restore  = mret_fire;
    assign mip_meip     = meip_pend_q;
    assign in_handler   = (state_q == StTake) | (state_q == StHandler);

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed self-checking bench for irq_sequencer.
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        intrpt, timer_irq;
    logic        csr_mie_bit, csr_meie, csr_mtie;
    logic [31:0] csr_mtvec, csr_mepc;
    logic        ex_valid, ex_stall, ex_br_taken, ex_mret;
    logic [31:0] ex_pc;
    logic        irq_flush, irq_redirect;
    logic [31:0] irq_pc;
    logic        mepc_we, mcause_we;
    logic [31:0] mepc_wdata, mcause_wdata;
    logic        mie_save, mie_restore, mip_meip, in_handler;

    int n_cmp = 0;
    int n_bad = 0;

    irq_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .intrpt       (intrpt),
        .timer_irq    (timer_irq),
        .csr_mie_bit  (csr_mie_bit),
        .csr_meie     (csr_meie),
        .csr_mtie     (csr_mtie),
        .csr_mtvec    (csr_mtvec),
        .csr_mepc     (csr_mepc),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_stall     (ex_stall),
        .ex_br_taken  (ex_br_taken),
        .ex_mret      (ex_mret),
        .irq_flush    (irq_flush),
        .irq_redirect (irq_redirect),
        .irq_pc       (irq_pc),
        .mepc_we      (mepc_we),
        .mepc_wdata   (mepc_wdata),
        .mcause_we    (mcause_we),
        .mcause_wdata (mcause_wdata),
        .mie_save     (mie_save),
        .mie_restore  (mie_restore),
        .mip_meip     (mip_meip),
        .in_handler   (in_handler)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Retire an mret in HANDLER: pulses checked in the same cycle
    task automatic do_mret(input logic [31:0] target);
        ex_mret  = 1'b1;
        csr_mepc = target;
        #1;
        check_eq("mret_flush", {31'b0, irq_flush}, 32'd1);
        check_eq("mret_restore", {31'b0, mie_restore}, 32'd1);
        check_eq("mret_pc", irq_pc, target);
        tick();
        ex_mret = 1'b0;
        check_eq("mret_inh", {31'b0, in_handler}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; intrpt = 1'b1; timer_irq = 1'b0;
        csr_mie_bit = 1'b0; csr_meie = 1'b1; csr_mtie = 1'b1;
        csr_mtvec = 32'h100; csr_mepc = 32'h0;
        ex_valid = 1'b1; ex_pc = 32'h40; ex_stall = 1'b0;
        ex_br_taken = 1'b0; ex_mret = 1'b0;

        // Reset with pin held high
        tick(); tick();
        check_eq("rst_flush", {31'b0, irq_flush}, 32'd0);
        check_eq("rst_redirect", {31'b0, irq_redirect}, 32'd0);
        check_eq("rst_pc", irq_pc, 32'h0);
        check_eq("rst_mepc_we", {31'b0, mepc_we}, 32'd0);
        check_eq("rst_mcause", mcause_wdata, 32'h0);
        check_eq("rst_save", {31'b0, mie_save}, 32'd0);
        check_eq("rst_mip", {31'b0, mip_meip}, 32'd0);
        check_eq("rst_inh", {31'b0, in_handler}, 32'd0);
        reset = 1'b0;
        tick(); check_eq("rst_mip_c1", {31'b0, mip_meip}, 32'd0);
        tick(); check_eq("rst_mip_c2", {31'b0, mip_meip}, 32'd0);
        tick(); check_eq("rst_mip_c3", {31'b0, mip_meip}, 32'd1);
        csr_mie_bit = 1'b1;
        tick(); check_eq("rst_arm_flush", {31'b0, irq_flush}, 32'd0);
        tick(); check_eq("rst_take_flush", {31'b0, irq_flush}, 32'd1);
        check_eq("rst_take_cause", mcause_wdata, 32'h8000_000B);
        tick(); check_eq("rst_mip_clr", {31'b0, mip_meip}, 32'd0);
        repeat (4) tick();
        check_eq("rst_edge_once", {31'b0, mip_meip}, 32'd0);
        check_eq("rst_inh_hold", {31'b0, in_handler}, 32'd1);
        do_mret(32'h40);
        intrpt = 1'b0;
        repeat (4) tick();

        // Basic external trap, direct mode
        csr_mtvec = 32'h100; ex_pc = 32'h40;
        intrpt = 1'b1;
        tick(); tick();
        intrpt = 1'b0;
        tick(); check_eq("bas_mip_c3", {31'b0, mip_meip}, 32'd1);
        check_eq("bas_flush_c3", {31'b0, irq_flush}, 32'd0);
        tick(); check_eq("bas_flush_c4", {31'b0, irq_flush}, 32'd0);
        tick();
        check_eq("bas_flush_c5", {31'b0, irq_flush}, 32'd1);
        check_eq("bas_redirect", {31'b0, irq_redirect}, 32'd1);
        check_eq("bas_pc", irq_pc, 32'h100);
        check_eq("bas_mepc_we", {31'b0, mepc_we}, 32'd1);
        check_eq("bas_mepc", mepc_wdata, 32'h40);
        check_eq("bas_mcause_we", {31'b0, mcause_we}, 32'd1);
        check_eq("bas_mcause", mcause_wdata, 32'h8000_000B);
        check_eq("bas_save", {31'b0, mie_save}, 32'd1);
        tick();
        check_eq("bas_width", {31'b0, irq_flush}, 32'd0);
        check_eq("bas_save_width", {31'b0, mie_save}, 32'd0);
        check_eq("bas_mip_clr", {31'b0, mip_meip}, 32'd0);
        check_eq("bas_inh", {31'b0, in_handler}, 32'd1);
        do_mret(32'h40);
        repeat (3) tick();

        // Priority and vectored mode
        csr_mtvec = 32'h201;
        intrpt = 1'b1;
        tick(); tick();
        intrpt = 1'b0;
        tick();
        timer_irq = 1'b1;
        tick();
        tick();
        check_eq("pri_flush", {31'b0, irq_flush}, 32'd1);
        check_eq("pri_pc_mei", irq_pc, 32'h22C);
        check_eq("pri_cause_mei", mcause_wdata, 32'h8000_000B);
        tick(); tick(); tick();
        check_eq("pri_hnd_hold", {31'b0, irq_flush}, 32'd0);
        do_mret(32'h40);
        check_eq("pri_idle_flush", {31'b0, irq_flush}, 32'd0);
        check_eq("pri_restore_width", {31'b0, mie_restore}, 32'd0);
        tick(); check_eq("pri_arm_flush", {31'b0, irq_flush}, 32'd0);
        tick();
        check_eq("pri_mti_flush", {31'b0, irq_flush}, 32'd1);
        check_eq("pri_pc_mti", irq_pc, 32'h21C);
        check_eq("pri_cause_mti", mcause_wdata, 32'h8000_0007);
        timer_irq = 1'b0;
        tick();
        do_mret(32'h40);
        tick();

        // Boundary hold
        csr_mtvec = 32'h100;
        ex_stall = 1'b1; ex_pc = 32'h5C; timer_irq = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ex_pc = 32'h60 + 32'(4 * i);
            tick();
            check_eq("bnd_stall", {31'b0, irq_flush}, 32'd0);
        end
        ex_stall = 1'b0; ex_br_taken = 1'b1; ex_pc = 32'h70;
        tick(); check_eq("bnd_branch", {31'b0, irq_flush}, 32'd0);
        ex_br_taken = 1'b0; ex_pc = 32'h74;
        tick();
        check_eq("bnd_take", {31'b0, irq_flush}, 32'd1);
        check_eq("bnd_mepc", mepc_wdata, 32'h74);
        check_eq("bnd_cause", mcause_wdata, 32'h8000_0007);
        check_eq("bnd_pc", irq_pc, 32'h100);
        timer_irq = 1'b0;
        tick();
        do_mret(32'h74);
        tick();

        // Disable while in ARM: back to IDLE with no pulses
        ex_valid = 1'b0; timer_irq = 1'b1;
        tick();
        csr_mie_bit = 1'b0;
        tick();
        check_eq("dis_flush", {31'b0, irq_flush}, 32'd0);
        check_eq("dis_mepc_we", {31'b0, mepc_we}, 32'd0);
        check_eq("dis_inh", {31'b0, in_handler}, 32'd0);
        csr_mie_bit = 1'b1; ex_valid = 1'b1;
        tick(); check_eq("dis_rearm", {31'b0, irq_flush}, 32'd0);
        tick(); check_eq("dis_take", {31'b0, irq_flush}, 32'd1);
        timer_irq = 1'b0;
        tick();

        // Second edge while in HANDLER stays pending until mret
        intrpt = 1'b1;
        tick(); tick();
        intrpt = 1'b0;
        tick(); check_eq("hnd_mip", {31'b0, mip_meip}, 32'd1);
        repeat (3) tick();
        check_eq("hnd_no_trap", {31'b0, irq_flush}, 32'd0);
        check_eq("hnd_inh", {31'b0, in_handler}, 32'd1);
        do_mret(32'h74);
        check_eq("hnd_idle", {31'b0, irq_flush}, 32'd0);
        tick(); check_eq("hnd_arm", {31'b0, irq_flush}, 32'd0);
        tick();
        check_eq("hnd_take", {31'b0, irq_flush}, 32'd1);
        check_eq("hnd_cause", mcause_wdata, 32'h8000_000B);
        tick(); check_eq("hnd_mip_clr", {31'b0, mip_meip}, 32'd0);

        // Abort from HANDLER with a pending edge
        intrpt = 1'b1;
        tick(); tick();
        intrpt = 1'b0;
        tick(); check_eq("abh_mip_pre", {31'b0, mip_meip}, 32'd1);
        reset = 1'b1;
        tick();
        check_eq("abh_inh", {31'b0, in_handler}, 32'd0);
        check_eq("abh_mip", {31'b0, mip_meip}, 32'd0);
        check_eq("abh_flush", {31'b0, irq_flush}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Abort from ARM
        ex_valid = 1'b0; timer_irq = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check_eq("aba_inh", {31'b0, in_handler}, 32'd0);
        check_eq("aba_mip", {31'b0, mip_meip}, 32'd0);
        reset = 1'b0; ex_valid = 1'b1;
        tick(); check_eq("aba_idle", {31'b0, irq_flush}, 32'd0);
        tick(); check_eq("aba_take", {31'b0, irq_flush}, 32'd1);
        timer_irq = 1'b0;
        tick();
        do_mret(32'h40);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
